// File: rtl/fetch_pc_if.sv
// Fetch PC unit bus: predictor/decoder inputs and fetch pipeline PC outputs.
// The fetch unit uses the master modport; the predictor/pipeline side uses slave.
interface fetch_pc_if;
  logic        if_is_comp;
  logic        if_prediction;
  logic [10:0] if_PBT;
  logic        id_is_jump;
  logic        id_jump_in_bht;
  logic [10:0] id_branchtarget;
  logic        id_mret;
  logic [1:0]  exe_correction;
  logic [10:0] exe_PBT;
  logic [10:0] exe_CNI;
  logic        flush;
  logic        int_req;
  logic [10:0] if_PC;
  logic [10:0] id_PC;
  logic [10:0] exe_PC;
  logic        id_valid;
  logic        exe_valid;
  logic        ISR_running;
  logic        int_ack;
  logic [15:0] perf_branches;
  logic [15:0] perf_mispredicts;

  modport master (
    input  if_is_comp, if_prediction, if_PBT, id_is_jump, id_jump_in_bht,
           id_branchtarget, id_mret, exe_correction, exe_PBT, exe_CNI, flush, int_req,
    output if_PC, id_PC, exe_PC, id_valid, exe_valid, ISR_running, int_ack,
           perf_branches, perf_mispredicts
  );

  modport slave (
    output if_is_comp, if_prediction, if_PBT, id_is_jump, id_jump_in_bht,
           id_branchtarget, id_mret, exe_correction, exe_PBT, exe_CNI, flush, int_req,
    input  if_PC, id_PC, exe_PC, id_valid, exe_valid, ISR_running, int_ack,
           perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC selection, IF->ID->EXE PC pipeline and interrupt entry/return sequencer.
// Optional performance counters are built when BP_PERF_EN is defined.
module fetch_pc_unit (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        en,
  input  logic        stall,
  fetch_pc_if.master  bus
);
  localparam int unsigned AW = 11;
  localparam int unsigned PW = 16;
  localparam logic [AW-1:0] RESET_PC   = 11'h000;
  localparam logic [AW-1:0] ISR_VECTOR = 11'h600;

  typedef enum logic [1:0] {S_RUN, S_ENTER, S_ISR, S_RETURN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] if_pc_q, id_pc_q, exe_pc_q, saved_pc_q, saved_pc_d;
  logic [AW-1:0] next_pc, seq_pc, corr_pc;
  logic          id_valid_q, exe_valid_q, isr_running_q;
  logic          active, corr_hit, squash, int_ack_c;

  assign active   = en && !stall;
  assign seq_pc   = if_pc_q + (bus.if_is_comp ? AW'(1) : AW'(2));
  assign corr_hit = bus.exe_correction[1];
  assign corr_pc  = bus.exe_correction[0] ? bus.exe_PBT : bus.exe_CNI;

  // Next-PC select and sequencer; ENTER/RETURN targets override EXE corrections
  always_comb begin
    state_d    = state_q;
    saved_pc_d = saved_pc_q;
    int_ack_c  = 1'b0;
    squash     = 1'b0;
    if (corr_hit)
      next_pc = corr_pc;
    else if (bus.id_is_jump && !bus.id_jump_in_bht && id_valid_q)
      next_pc = bus.id_branchtarget;
    else if (bus.if_prediction)
      next_pc = bus.if_PBT;
    else
      next_pc = seq_pc;

    case (state_q)
      S_RUN: begin
        if (bus.int_req && !corr_hit) begin
          state_d    = S_ENTER;
          saved_pc_d = seq_pc;
        end
      end
      S_ENTER: begin
        next_pc   = ISR_VECTOR;
        int_ack_c = active;
        squash    = 1'b1;
        state_d   = S_ISR;
        if (corr_hit) saved_pc_d = corr_pc;
      end
      S_ISR: begin
        if (bus.id_mret && id_valid_q) state_d = S_RETURN;
      end
      S_RETURN: begin
        next_pc = saved_pc_q;
        squash  = 1'b1;
        state_d = S_RUN;
        if (corr_hit) saved_pc_d = corr_pc;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nrst)
      state_q <= S_RUN;
    else if (active)
      state_q <= state_d;
  end

  // PC pipeline; squash kills both younger slots on interrupt entry/return
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      if_pc_q       <= RESET_PC;
      id_pc_q       <= '0;
      exe_pc_q      <= '0;
      saved_pc_q    <= '0;
      id_valid_q    <= 1'b0;
      exe_valid_q   <= 1'b0;
      isr_running_q <= 1'b0;
    end else if (active) begin
      if_pc_q     <= next_pc;
      id_pc_q     <= if_pc_q;
      exe_pc_q    <= id_pc_q;
      saved_pc_q  <= saved_pc_d;
      id_valid_q  <= !bus.flush && !squash;
      exe_valid_q <= id_valid_q && !bus.flush && !squash;
      if (state_q == S_ENTER)
        isr_running_q <= 1'b1;
      else if (state_q == S_RETURN)
        isr_running_q <= 1'b0;
    end
  end

`ifdef BP_PERF_EN
  logic [PW-1:0] branches_q, mispredicts_q;

  // Saturating resolved-branch and misprediction counters
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (active) begin
      if (exe_valid_q && bus.exe_correction != 2'b01 && branches_q != '1)
        branches_q <= branches_q + PW'(1);
      if (corr_hit && mispredicts_q != '1)
        mispredicts_q <= mispredicts_q + PW'(1);
    end
  end

  assign bus.perf_branches    = branches_q;
  assign bus.perf_mispredicts = mispredicts_q;
`else
  assign bus.perf_branches    = PW'(0);
  assign bus.perf_mispredicts = PW'(0);
`endif

  assign bus.if_PC       = if_pc_q;
  assign bus.id_PC       = id_pc_q;
  assign bus.exe_PC      = exe_pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.exe_valid   = exe_valid_q;
  assign bus.ISR_running = isr_running_q;
  assign bus.int_ack     = int_ack_c;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: expected fetch PCs are queued when
// stimulus is driven and popped after the edge that should produce them.
module tb_fetch_pc_unit;
  logic CLK = 1'b0;
  logic nrst, en, stall;

  fetch_pc_if bus();

  fetch_pc_unit dut (.CLK(CLK), .nrst(nrst), .en(en), .stall(stall), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [10:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_pc(input string name, input logic [10:0] pc);
    exp_t x;
    x.name = name;
    x.pc   = pc;
    exp_q.push_back(x);
  endtask

  task automatic clear_inputs();
    bus.if_is_comp = 0; bus.if_prediction = 0; bus.if_PBT = '0;
    bus.id_is_jump = 0; bus.id_jump_in_bht = 0; bus.id_branchtarget = '0;
    bus.id_mret = 0; bus.exe_correction = 2'b00; bus.exe_PBT = '0; bus.exe_CNI = '0;
    bus.flush = 0; bus.int_req = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    en = 1; stall = 0; nrst = 0;
    step(); step();
    n_checks++; if (bus.if_PC !== 11'h000) $display("FAIL reset_if_pc: got %h want 000", bus.if_PC); else n_pass++;
    n_checks++; if ({bus.id_PC, bus.exe_PC} !== 22'h0) $display("FAIL reset_pipe_pc: got %h/%h want 0/0", bus.id_PC, bus.exe_PC); else n_pass++;
    n_checks++; if ({bus.id_valid, bus.exe_valid, bus.ISR_running, bus.int_ack} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {bus.id_valid, bus.exe_valid, bus.ISR_running, bus.int_ack}); else n_pass++;
    n_checks++; if ({bus.perf_branches, bus.perf_mispredicts} !== 32'h0)
      $display("FAIL reset_perf: got %h/%h want 0/0", bus.perf_branches, bus.perf_mispredicts); else n_pass++;
  endtask

  task automatic test_sequential();
    logic        comp [3] = '{1'b0, 1'b1, 1'b0};
    logic [10:0] pcs  [3] = '{11'h002, 11'h003, 11'h005};
    nrst = 1;
    for (int i = 0; i < 3; i++) begin
      bus.if_is_comp = comp[i];
      push_pc($sformatf("seq_%0d", i), pcs[i]);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    end
    n_checks++; if ({bus.id_PC, bus.exe_PC} !== {11'h003, 11'h002})
      $display("FAIL seq_pipe: id_PC=%h exe_PC=%h want 003/002", bus.id_PC, bus.exe_PC); else n_pass++;
    n_checks++; if ({bus.id_valid, bus.exe_valid} !== 2'b11)
      $display("FAIL seq_valid: got %b want 11", {bus.id_valid, bus.exe_valid}); else n_pass++;
    bus.if_is_comp = 0;
  endtask

  task automatic test_correction();
    logic        pred [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [10:0] ipbt [4] = '{11'h010, 11'h040, 11'h000, 11'h000};
    logic [1:0]  corr [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [10:0] pcs  [4] = '{11'h010, 11'h020, 11'h0A0, 11'h0A2};
    bus.exe_PBT = 11'h0A0;
    bus.exe_CNI = 11'h020;
    for (int i = 0; i < 4; i++) begin
      bus.if_prediction = pred[i]; bus.if_PBT = ipbt[i]; bus.exe_correction = corr[i];
      push_pc($sformatf("corr_%0d", i), pcs[i]);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_jump();
    logic        bht [2] = '{1'b0, 1'b1};
    logic [10:0] pcs [2] = '{11'h100, 11'h050};
    bus.id_is_jump = 1; bus.id_branchtarget = 11'h100;
    bus.if_prediction = 1; bus.if_PBT = 11'h050;
    for (int i = 0; i < 2; i++) begin
      bus.id_jump_in_bht = bht[i];
      push_pc($sformatf("jump_%0d", i), pcs[i]);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    logic        pred [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [10:0] ipbt [4] = '{11'h7FF, 11'h000, 11'h7FE, 11'h000};
    logic        comp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [10:0] pcs  [4] = '{11'h7FF, 11'h000, 11'h7FE, 11'h000};
    for (int i = 0; i < 4; i++) begin
      bus.if_prediction = pred[i]; bus.if_PBT = ipbt[i]; bus.if_is_comp = comp[i];
      push_pc($sformatf("wrap_%0d", i), pcs[i]);
      step();
      e = exp_q.pop_front();
      n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    logic       fl  [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0] val [3] = '{2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      bus.flush = fl[i];
      step();
      n_checks++; if ({bus.id_valid, bus.exe_valid} !== val[i])
        $display("FAIL flush_%0d: valids=%b want %b", i, {bus.id_valid, bus.exe_valid}, val[i]); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_interrupt();
    bus.if_prediction = 1; bus.if_PBT = 11'h030;
    push_pc("int_setup", 11'h030);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    bus.if_prediction = 0; bus.int_req = 1;
    push_pc("int_seq", 11'h032);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    n_checks++; if (bus.int_ack !== 1'b1) $display("FAIL int_ack_enter: got %b want 1", bus.int_ack); else n_pass++;
    push_pc("int_vector", 11'h600);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    n_checks++; if ({bus.ISR_running, bus.int_ack, bus.id_valid, bus.exe_valid} !== 4'b1000)
      $display("FAIL int_in_isr: isr/ack/idv/exv=%b want 1000", {bus.ISR_running, bus.int_ack, bus.id_valid, bus.exe_valid}); else n_pass++;
    // int_req stays high throughout the handler
    for (int i = 1; i <= 3; i++) begin
      push_pc($sformatf("isr_seq_%0d", i), 11'h600 + 11'(2 * i));
      step();
      e = exp_q.pop_front();
      n_checks++; if (bus.if_PC !== e.pc || bus.int_ack !== 1'b0)
        $display("FAIL %s: if_PC=%h ack=%b want %h/0", e.name, bus.if_PC, bus.int_ack, e.pc); else n_pass++;
    end
    bus.int_req = 0; bus.id_mret = 1;
    push_pc("mret_seq", 11'h608);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.ISR_running !== 1'b1)
      $display("FAIL %s: if_PC=%h isr=%b want %h/1", e.name, bus.if_PC, bus.ISR_running, e.pc); else n_pass++;
    bus.id_mret = 0;
    push_pc("mret_return", 11'h032);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    n_checks++; if ({bus.ISR_running, bus.id_valid, bus.exe_valid} !== 3'b000)
      $display("FAIL mret_flags: isr/idv/exv=%b want 000", {bus.ISR_running, bus.id_valid, bus.exe_valid}); else n_pass++;
    push_pc("post_return", 11'h034);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.ISR_running !== 1'b0 || bus.int_ack !== 1'b0)
      $display("FAIL %s: if_PC=%h isr=%b ack=%b want %h/0/0", e.name, bus.if_PC, bus.ISR_running, bus.int_ack, e.pc); else n_pass++;
  endtask

  task automatic test_stall();
    bus.int_req = 1; bus.exe_correction = 2'b11; bus.exe_PBT = 11'h123; stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if ({bus.if_PC, bus.id_PC} !== {11'h034, 11'h032} || bus.int_ack !== 1'b0 || bus.ISR_running !== 1'b0)
        $display("FAIL stall_%0d: if_PC=%h id_PC=%h ack=%b isr=%b want 034/032/0/0", i, bus.if_PC, bus.id_PC, bus.int_ack, bus.ISR_running);
      else n_pass++;
    end
    stall = 0; en = 0;
    step();
    n_checks++; if (bus.if_PC !== 11'h034) $display("FAIL en_low: if_PC=%h want 034", bus.if_PC); else n_pass++;
    en = 1;
    push_pc("stall_release_corr", 11'h123);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.int_ack !== 1'b0)
      $display("FAIL %s: if_PC=%h ack=%b want %h/0", e.name, bus.if_PC, bus.int_ack, e.pc); else n_pass++;
    bus.exe_correction = 2'b00;
    push_pc("enter_seq", 11'h125);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    stall = 1;
    #1;
    n_checks++; if (bus.int_ack !== 1'b0) $display("FAIL ack_stalled: got %b want 0", bus.int_ack); else n_pass++;
    step();
    n_checks++; if (bus.if_PC !== 11'h125 || bus.int_ack !== 1'b0)
      $display("FAIL enter_hold: if_PC=%h ack=%b want 125/0", bus.if_PC, bus.int_ack); else n_pass++;
    stall = 0;
    #1;
    n_checks++; if (bus.int_ack !== 1'b1) $display("FAIL ack_unstalled: got %b want 1", bus.int_ack); else n_pass++;
    // A correction during ENTER retargets the return address, not the fetch
    bus.exe_correction = 2'b11; bus.exe_PBT = 11'h222;
    push_pc("enter_corr_vector", 11'h600);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.ISR_running !== 1'b1)
      $display("FAIL %s: if_PC=%h isr=%b want %h/1", e.name, bus.if_PC, bus.ISR_running, e.pc); else n_pass++;
    bus.exe_correction = 2'b00; bus.int_req = 0;
    push_pc("isr_step", 11'h602);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    bus.id_mret = 1;
    push_pc("mret2_seq", 11'h604);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc) $display("FAIL %s: if_PC=%h want %h", e.name, bus.if_PC, e.pc); else n_pass++;
    bus.id_mret = 0;
    push_pc("mret2_saved_corr", 11'h222);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.ISR_running !== 1'b0)
      $display("FAIL %s: if_PC=%h isr=%b want %h/0", e.name, bus.if_PC, bus.ISR_running, e.pc); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_in_isr();
    bus.int_req = 1;
    step();
    bus.int_req = 0;
    step();
    n_checks++; if (bus.if_PC !== 11'h600 || bus.ISR_running !== 1'b1)
      $display("FAIL rst_isr_entry: if_PC=%h isr=%b want 600/1", bus.if_PC, bus.ISR_running); else n_pass++;
    nrst = 0;
    step();
    n_checks++; if (bus.if_PC !== 11'h000 || bus.ISR_running !== 1'b0 || bus.id_valid !== 1'b0)
      $display("FAIL rst_isr_reset: if_PC=%h isr=%b idv=%b want 000/0/0", bus.if_PC, bus.ISR_running, bus.id_valid); else n_pass++;
    nrst = 1;
    push_pc("rst_isr_run", 11'h002);
    step();
    e = exp_q.pop_front();
    n_checks++; if (bus.if_PC !== e.pc || bus.ISR_running !== 1'b0 || bus.int_ack !== 1'b0)
      $display("FAIL %s: if_PC=%h isr=%b ack=%b want %h/0/0", e.name, bus.if_PC, bus.ISR_running, bus.int_ack, e.pc); else n_pass++;
  endtask

  task automatic test_perf();
`ifdef BP_PERF_EN
    nrst = 0;
    step();
    nrst = 1; bus.exe_correction = 2'b10; bus.exe_CNI = 11'h000;
    for (int i = 0; i < 65536; i++) @(posedge CLK);
    #1;
    n_checks++; if (bus.perf_mispredicts !== 16'hFFFF) $display("FAIL perf_mispredicts: got %h want FFFF", bus.perf_mispredicts); else n_pass++;
    n_checks++; if (bus.perf_branches !== 16'hFFFE) $display("FAIL perf_branches: got %h want FFFE", bus.perf_branches); else n_pass++;
    clear_inputs();
`else
    n_checks++; if ({bus.perf_branches, bus.perf_mispredicts} !== 32'h0)
      $display("FAIL perf_tied: got %h/%h want 0/0", bus.perf_branches, bus.perf_mispredicts); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_correction();
    test_jump();
    test_wrap();
    test_flush();
    test_interrupt();
    test_stall();
    test_reset_in_isr();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
